// File: rtl/tt_um_carlos_uart_tx.sv
// tt_um_carlos_uart_tx: byte-in / UART-out Tiny Tapeout tile.
// Bytes on ui_in are captured on a synchronized rising edge of uio_in[0],
// queued in a small circular FIFO, and serialized LSB-first on uio_out[1].
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit, 8E1 frame).
module tt_um_carlos_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int             PW        = $clog2(DEPTH);
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [3:0]     DEPTH_C   = 4'(DEPTH);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // Strobe synchronizer and edge detect
    logic sync_q1, sync_q2, sync_q3;
    logic wr_req;

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          full, push, pop;
    logic          overflow;

    // Transmitter
    state_t        state, state_next;
    logic [BW-1:0] baud_cnt;
    logic          bit_done;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          tx_q, tx_next;
    logic          busy;
`ifdef TX_PARITY_EN
    logic          parity_q;
`endif

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

    // Two-flop synchronizer on the strobe pin plus a history flop for edge detect
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= uio_in[0];
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign wr_req   = sync_q2 & ~sync_q3;
    assign full     = (count == DEPTH_C);
    assign push     = wr_req & ~full;
    assign bit_done = (baud_cnt == BAUD_LAST);

    // FIFO pointers, occupancy and sticky overflow; a write into a full FIFO is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {3'b000, push} - {3'b000, pop};
            if (wr_req && full) overflow <= 1'b1;
        end
    end

    // FIFO storage
    // NOTE: the array has no reset; emptiness is carried by count and pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ui_in;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != 4'd0) state_next = S_START;
            S_START: if (bit_done)      state_next = S_DATA;
            S_DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: if (bit_done) state_next = S_STOP;
`endif
            S_STOP: begin
                if (bit_done) state_next = (count != 4'd0) ? S_START : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and the next value of the line
    always_comb begin
        pop     = 1'b0;
        tx_next = 1'b1;
        case (state)
            S_IDLE:  pop     = (count != 4'd0);
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_q[0];
`ifdef TX_PARITY_EN
            S_PARITY: tx_next = parity_q;
`endif
            S_STOP:  pop     = bit_done && (count != 4'd0);
            default: tx_next = 1'b1;
        endcase
    end

    // Bit timer, shift register and registered line output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_q <= tx_next;
            if (pop) begin
                shift_q  <= mem[rd_ptr];
                baud_cnt <= '0;
                bit_idx  <= '0;
`ifdef TX_PARITY_EN
                parity_q <= ^mem[rd_ptr];
`endif
            end else if (state != S_IDLE) begin
                if (bit_done) begin
                    baud_cnt <= '0;
                    if (state == S_DATA) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    assign busy    = (state != S_IDLE) | (count != 4'd0);
    assign uio_out = {4'b0000, full, busy, tx_q, 1'b0};
    assign uio_oe  = 8'b0000_1110;
    assign uo_out  = {overflow, 3'b000, count};

endmodule

// File: doc/tt_um_carlos_uart_tx.md
# tt_um_carlos_uart_tx

Tiny Tapeout user tile that is the transmit end of the tile's byte interface. Where the existing tile only consumes `uio` pins as inputs, this tile drives them as outputs. Bytes on `ui_in` are captured on a rising strobe on `uio_in[0]` and held in a small FIFO. They are then serialized as 8N1 UART frames on `uio_out[1]`. Status (busy, full, FIFO level, overflow) is exported on `uio_out` and `uo_out`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; minimum 2.
- `DEPTH`, default 4: FIFO entries; a power of 2, from 2 to 8.

Ports (clock and reset first):
- `clk`  in  1  tile clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  always 1 when powered; ignored.
- `ui_in`  in  8  byte to transmit; sampled on the write cycle.
- `uio_in`  in  8  bit 0 = write strobe (asynchronous pin); other bits are ignored.
- `uio_out`  out  8  bit 1 = `tx`, bit 2 = `busy`, bit 3 = `full`; all other bits are 0.
- `uio_oe`  out  8  constant 8'b0000_1110.
- `uo_out`  out  8  bit 7 = `overflow`; bits [3:0] = FIFO count (0..DEPTH); bits [6:4] = 0.

## Operation
- **Strobe capture:** `uio_in[0]` passes through a 2-flop synchronizer plus an edge flop. A write request lasts exactly one cycle, the cycle in which the synchronized level is 1 and the previous level was 0.
- **Write accepted:** if `count < DEPTH` (registered count), `ui_in` is pushed in the write cycle.
- **Write dropped:** if `count == DEPTH`, the write is dropped and `overflow` is set. A pop in the same cycle does not rescue the write. `overflow` is sticky and is cleared only by reset.
- **FIFO storage:** circular buffer with wrapping read and write pointers. The count is updated by push and pop in the same cycle; a simultaneous push and pop leaves the count unchanged.
- **FSM states:** IDLE, START, DATA, STOP, plus PARITY when the parity option is compiled in.
- **IDLE:** `tx` = 1. If `count > 0`, pop the head into the shift register and go to START.
- **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** 8 bits, LSB first, `CLKS_PER_BIT` cycles each. A 3-bit bit index moves to STOP (or PARITY) after bit 7.
- **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles. On the last cycle, if `count > 0`, pop and go directly to START, so there is no idle gap. Otherwise go to IDLE.
- **Status outputs:** `busy` = (state != IDLE) | (count != 0). `full` = (count == DEPTH).
- **Output register:** `tx` is registered and glitch-free.

## Timing
- **Reset values:** state IDLE, `tx` = 1, `busy` = 0, `full` = 0, count 0, pointers 0, `overflow` = 0, synchronizer flops 0. `uio_oe` is constant.
- **Strobe latency:** a strobe rising before clock edge k produces its write cycle W at edge k+2. The data byte must be stable from W-1 through W.
- **Count latency:** the count reflects the push from cycle W+1.
- **Start-bit latency:** from IDLE with an empty FIFO, the pop occurs at W+1 and `tx` falls at W+2.
- **Frame length:** 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity. Back-to-back frames are contiguous.
- **Reset mid-frame:** on the next edge `tx` = 1 and the FIFO is emptied. The partial frame is abandoned and no later bits are emitted.
- **Strobe minimum:** the strobe must stay high at least 2 cycles and low at least 2 cycles between writes.

## Configuration
- **Macro:** `TX_PARITY_EN`.
- **When defined:** the PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, giving an 8E1 frame of 11 bits.
- **When undefined:** there is no PARITY state and the frame is 8N1, 10 bits. All other behaviour is identical.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `DEPTH` = 4.
- **Reset:** hold `rst_n` = 0 for 3 cycles → `tx` = 1, `uo_out` = 0x00, `uio_out` = 0x02, `uio_oe` = 0x0E.
- **Single byte:** write 0xA5 → `tx` falls at W+2. Bits read 0,1,0,1,0,0,1,0,1,1, each lasting 4 cycles. `busy` drops after 40 cycles (44 with parity, parity bit = 0).
- **Back-to-back:** write 0x00, 0xFF, 0x3C quickly → three contiguous frames with no idle cycles between stop and start. `count` peaks at 2 (the first byte is popped immediately).
- **Overflow:** while a frame is active, write 5 more bytes → `full` = 1 after 4, the 5th is dropped, and `uo_out[7]` = 1. Exactly 5 frames are sent in total (the active one plus 4 queued). `overflow` stays 1 until reset.
- **Reset mid-frame:** assert `rst_n` = 0 during DATA bit 3 of 0x55 with 2 bytes queued → `tx` = 1 on the next edge, count = 0. No further frames are sent after release.
- **Strobe filtering:** hold the strobe high for 20 cycles → exactly one write. Toggling faster than 2 cycles is outside the specified behaviour and is not checked.
